// File: rtl/obstacle_gen.sv
// Pseudo-random obstacle column source: a 16-bit Galois LFSR feeds a GAP/OBST
// run-length FSM that hands the runner datapath one 2-bit column height per advance.
//
// state | meaning
// IDLE  | waiting for start; advance ignored, col_valid low
// GAP   | emitting rem empty (height 0) columns
// OBST  | emitting rem columns of obstacle height h
module obstacle_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MIN_GAP   = 4,
  parameter int          MAX_GAP   = 15,
  parameter int          MAX_WIDTH = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       advance,
  output logic [1:0] col_out,
  output logic       col_valid,
  output logic [1:0] state_out,
  output logic [7:0] obstacle_count
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    OBST = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [4:0]  rem;
  logic [1:0]  h;

  logic [15:0] lfsr_next;
  logic [4:0]  gap_sum;
  logic [4:0]  gap_len;
  logic [1:0]  height;
  logic [4:0]  width;

  // All fields come from the LFSR value before the step taken on this advance.
  always_comb begin
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    gap_sum   = 5'(MIN_GAP) + {1'b0, lfsr[3:0]};
    gap_len   = (gap_sum > 5'(MAX_GAP)) ? 5'(MAX_GAP) : gap_sum;
    case (lfsr[5:4])
      2'b00:   height = 2'd1;
      2'b11:   height = 2'd2;
      default: height = lfsr[5:4];
    endcase
    width = ((MAX_WIDTH >= 2) && lfsr[6]) ? 5'd2 : 5'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      lfsr           <= SEED_EFF;
      rem            <= 5'd0;
      h              <= 2'd0;
      col_out        <= 2'd0;
      col_valid      <= 1'b0;
      obstacle_count <= 8'd0;
    end else if (start) begin
      state          <= GAP;
      lfsr           <= SEED_EFF;
      rem            <= 5'(MIN_GAP);
      col_out        <= 2'd0;
      col_valid      <= 1'b1;
      obstacle_count <= 8'd0;
    end else if (advance && (state != IDLE)) begin
      lfsr <= lfsr_next;
      case (state)
        GAP: begin
          if (rem > 5'd1) begin
            rem     <= rem - 5'd1;
            col_out <= 2'd0;
          end else begin
            state   <= OBST;
            h       <= height;
            rem     <= width;
            col_out <= height;
          end
        end
        OBST: begin
          if (rem > 5'd1) begin
            rem     <= rem - 5'd1;
            col_out <= h;
          end else begin
            state   <= GAP;
            rem     <= gap_len;
            col_out <= 2'd0;
            if (obstacle_count != 8'hFF)
              obstacle_count <= obstacle_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: doc/obstacle_gen.md
Name: obstacle_gen

Overview:
- Pseudo-random obstacle column source that sits directly upstream of the runner datapath.
- Replaces the fixed 320-bit obstacle pattern: it presents one 2-bit column height at a time.
- The datapath samples col_out whenever it scrolls and pulses advance in that same cycle; the block then prepares the next column.
- Built around a 16-bit Galois LFSR and a GAP/OBST run-length state machine that guarantees jumpable spacing.

Parameters:
- SEED, 16'hACE1, LFSR value loaded on start. A value of 0 is replaced by 16'h0001.
- MIN_GAP, 4, minimum run of empty (height 0) columns between obstacles. Also the length of the first gap after start.
- MAX_GAP, 15, gap length saturation limit. Must be >= MIN_GAP.
- MAX_WIDTH, 2, maximum obstacle width in columns. Legal values are 1 or 2.

Ports:
- clk, input, 1, system clock (CLOCK_50 at top level).
- resetn, input, 1, asynchronous active-low reset.
- start, input, 1, synchronous (re)initialise. Driven by the control FSM start output.
- advance, input, 1, single-cycle pulse: the datapath consumes col_out this cycle.
- col_out, output, 2, height of the column to be consumed on the next advance.
- col_valid, output, 1, high once start has been seen since reset.
- state_out, output, 2, current state: 0 = IDLE, 1 = GAP, 2 = OBST.
- obstacle_count, output, 8, number of completed obstacles, saturating at 255.

Behaviour:
Reset (async, resetn=0):
- State IDLE; lfsr = SEED (0 mapped to 1).
- col_out = 0, col_valid = 0, obstacle_count = 0; run counters rem = 0, h = 0.

LFSR:
- Next value = (lfsr >> 1) XOR (lfsr[0] ? 16'hB400 : 16'h0000).
- Steps only on an accepted advance (state GAP or OBST, start = 0).
- All derived fields below are taken from the lfsr value *before* that step.

Derived fields:
- gap_len = MIN_GAP + lfsr[3:0], saturated to MAX_GAP. Use a 5-bit sum so there is no wrap.
- height:
  - lfsr[5:4] = 00 -> 1
  - 11 -> 2
  - else lfsr[5:4]
  - Obstacle heights are therefore always 1 or 2.
- width = 1 + lfsr[6], clamped to MAX_WIDTH.

rem:
- Number of columns left in the current segment, including the one currently on col_out.

Transitions (at posedge clk):
- start = 1 (any state, highest priority):
  - lfsr = SEED; state GAP; rem = MIN_GAP.
  - col_out = 0, col_valid = 1, obstacle_count = 0.
  - An advance in the same cycle is ignored.
- IDLE: advance is ignored; outputs hold.
- GAP, advance, rem > 1: rem = rem - 1; col_out stays 0.
- GAP, advance, rem = 1:
  - state OBST; h = height; rem = width; col_out = height.
- OBST, advance, rem > 1: rem = rem - 1; col_out stays h.
- OBST, advance, rem = 1:
  - state GAP; rem = gap_len; col_out = 0.
  - obstacle_count = obstacle_count + 1, holding at 255.
- advance = 0: everything holds, including the LFSR.

Timing and usage:
- col_out changes only on the edge that ends an advance cycle, so the value the datapath samples with advance is the old column.
- Back-to-back advance pulses on consecutive cycles are legal and each is consumed.
- Holding advance high for N cycles consumes N columns.
- Guarantees: every obstacle is followed by at least MIN_GAP zero columns, and no obstacle is wider than MAX_WIDTH.
- Reset asserted mid-segment returns to IDLE immediately, regardless of the clock.

Test Plan:
1. Reset, then check outputs: col_out = 0, col_valid = 0, state_out = 0. Apply 3 advance pulses → no change; lfsr still 16'hACE1.
2. Start with defaults, then 3 advances → col_out = 0 throughout, state GAP. The internal lfsr sequence is ACE1 → E270 → 7138 → 389C.
3. Continue with a 4th advance (lfsr = 389C) → col_out = 1, state OBST, rem = 1. lfsr becomes 1C4E.
4. Continue with a 5th advance (lfsr = 1C4E, gap 4 + 14 = 18 saturates) → state GAP, rem = 15, col_out = 0, obstacle_count = 1. lfsr becomes 0E27.
5. Assert start and advance together mid-OBST → state GAP, rem = 4, lfsr = ACE1, obstacle_count = 0 (the advance is ignored).
6. Free run 10 000 advances with a scoreboard. Check:
   - every nonzero run length ≤ MAX_WIDTH;
   - every zero run ≥ MIN_GAP and ≤ MAX_GAP;
   - heights only ever take the values 1 and 2;
   - obstacle_count saturates at 255.
   Then force SEED = 0 → lfsr loads 16'h0001 and is never stuck at zero.
